// File: rtl/farm_sensor_req.sv
// farm_sensor_req
//   Producer side of the traffic-light controller's farm-road sensor input.
//   The raw loop-detector level is synchronized, debounced and turned into
//   arrival pulses. These drive a small IDLE/REQ/SERVE machine that holds a
//   registered request until the controller shows farm green, then re-arms.
//   Also reports wait-time urgency and malformed light codes.
//
// Parameters
//   DEBOUNCE_CYCLES  enabled samples needed to flip the debounced level (1..7)
//   CNT_W            width of the pending-vehicle counter
//   MAX_WAIT         enabled cycles in REQ before urgent asserts (1..31)
//
// Ports
//   clk           clock
//   rst_n         synchronous active-low reset
//   ena           enable; when low all state except the synchronizer freezes
//   loop_raw      asynchronous loop-detector level, 1 = vehicle present
//   light_farm    one-hot farm light: 100 red, 010 yellow, 001 green
//   req_c         registered vehicle request (controller input C)
//   veh_count     arrivals pending service, saturating
//   urgent        request has waited at least MAX_WAIT enabled cycles
//   light_err     sticky: a non-one-hot light_farm value was sampled
//   sensor_stuck  debounced level high for 63 enabled cycles
//
// Build option
//   FARM_REQ_STUCK_EN  enables the stuck-sensor counter; otherwise
//                      sensor_stuck is tied low.

module farm_sensor_req #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int MAX_WAIT        = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             loop_raw,
  input  logic [2:0]       light_farm,
  output logic             req_c,
  output logic [CNT_W-1:0] veh_count,
  output logic             urgent,
  output logic             light_err,
  output logic             sensor_stuck
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  localparam logic [2:0]       DC_LAST    = 3'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]       MAX_WAIT_C = 5'(MAX_WAIT);
  localparam logic [4:0]       WAIT_SAT   = 5'h1f;
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer; runs every cycle so the sampled level is never
  // stale when ena comes back.
  // ---------------------------------------------------------------------
  logic s1, s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= loop_raw;
      s2 <= s1;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer: dc counts consecutive enabled samples that disagree with db.
  // The toggle fires on the sample where the old dc already equals
  // DEBOUNCE_CYCLES-1, i.e. the DEBOUNCE_CYCLES-th disagreeing sample.
  // ---------------------------------------------------------------------
  logic       db;
  logic [2:0] dc;
  logic       db_toggle;
  logic       db_rise;
  logic       db_fall;

  assign db_toggle = ena && (s2 != db) && (dc == DC_LAST);
  assign db_rise   = db_toggle && !db;
  assign db_fall   = db_toggle &&  db;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db <= 1'b0;
      dc <= 3'd0;
    end else if (ena) begin
      if (s2 != db) begin
        if (dc == DC_LAST) begin
          db <= ~db;
          dc <= 3'd0;
        end else begin
          dc <= dc + 3'd1;
        end
      end else begin
        dc <= 3'd0;
      end
    end
  end

  // Arrival pulse is registered so the FSM and counter react one enabled
  // edge after db rises. It holds through ena=0 and is consumed on the next
  // enabled edge.
  logic arr;

  always_ff @(posedge clk) begin
    if (!rst_n)   arr <= 1'b0;
    else if (ena) arr <= db_rise;
  end

  // ---------------------------------------------------------------------
  // Light decode. Anything other than a clean one-hot code is an error and
  // never counts as green.
  // ---------------------------------------------------------------------
  logic onehot;
  logic green;

  assign onehot = (light_farm == 3'b100) || (light_farm == 3'b010) ||
                  (light_farm == 3'b001);
  assign green  = (light_farm == 3'b001);

  // ---------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [4:0]       wait_q, wait_nx;
  logic             urgent_nx;
  logic             serve_entry;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ena) begin
      case (state)
        ST_IDLE:  if (arr)    state_nx = ST_REQ;
        ST_REQ:   if (green)  state_nx = ST_SERVE;
        ST_SERVE: if (!green) state_nx = (veh_count != '0) ? ST_REQ : ST_IDLE;
        default:              state_nx = ST_IDLE;
      endcase
    end
  end

  assign serve_entry = (state == ST_REQ) && (state_nx == ST_SERVE);

  // Vehicle counter: service clears the backlog, but an arrival landing on
  // the same edge is kept as the next pending vehicle.
  always_comb begin
    cnt_nx = veh_count;
    if (ena) begin
      if (serve_entry)
        cnt_nx = arr ? CNT_W'(1) : '0;
      else if (arr && (veh_count != CNT_SAT))
        cnt_nx = veh_count + CNT_W'(1);
    end
  end

  // Wait counter only advances while staying in REQ; any entry into or
  // exit from REQ restarts it at zero.
  always_comb begin
    wait_nx = wait_q;
    if (ena) begin
      if ((state == ST_REQ) && (state_nx == ST_REQ))
        wait_nx = (wait_q == WAIT_SAT) ? wait_q : wait_q + 5'd1;
      else
        wait_nx = 5'd0;
    end
  end

  // Computed from next-state values so urgent lines up with req_c.
  assign urgent_nx = (state_nx == ST_REQ) && (wait_nx >= MAX_WAIT_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_c     <= 1'b0;
      veh_count <= '0;
      wait_q    <= 5'd0;
      urgent    <= 1'b0;
      light_err <= 1'b0;
    end else if (ena) begin
      req_c     <= (state_nx == ST_REQ);
      veh_count <= cnt_nx;
      wait_q    <= wait_nx;
      urgent    <= urgent_nx;
      if (!onehot) light_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Stuck-sensor detector
  // ---------------------------------------------------------------------
`ifdef FARM_REQ_STUCK_EN
  logic [5:0] stuck_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stuck_cnt    <= 6'd0;
      sensor_stuck <= 1'b0;
    end else if (ena) begin
      if (db_fall) begin
        stuck_cnt    <= 6'd0;
        sensor_stuck <= 1'b0;
      end else if (db) begin
        if (stuck_cnt != 6'd63) stuck_cnt <= stuck_cnt + 6'd1;
        if (stuck_cnt >= 6'd62) sensor_stuck <= 1'b1;
      end else begin
        stuck_cnt <= 6'd0;
      end
    end
  end
`else
  assign sensor_stuck = 1'b0;
`endif

endmodule
